// File: rtl/gray_fifo_ptr_ctrl_pkg.sv
// Shared constants and the binary-to-Gray helper for the FIFO pointer controller.
// Optional error flagging is controlled by GRAY_FIFO_PTR_ERR_EN (see top).
package memctrl_gray_pkg;

  localparam int AW_DEFAULT = 4;
  localparam int GRAY_MAX_W = 16;  // widest pointer: AW=15 -> 16 bits

  // Pointers narrower than GRAY_MAX_W are zero-extended by the caller.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_fifo_ptr_ctrl_if.sv
// Request/grant and status bundle for the FIFO pointer controller.
// master = requester side, slave = controller side.
interface gray_fifo_ptr_ctrl_if
  import memctrl_gray_pkg::*;
#(
  parameter int AW = AW_DEFAULT
);
  logic          flush;
  logic          wr_req;
  logic          rd_req;
  logic          wr_grant;
  logic          rd_grant;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   wr_gray;
  logic [AW:0]   rd_gray;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          err;

  modport master (
    output flush, wr_req, rd_req,
    input  wr_grant, rd_grant, wr_addr, rd_addr, wr_gray, rd_gray,
           full, empty, level, err
  );

  modport slave (
    input  flush, wr_req, rd_req,
    output wr_grant, rd_grant, wr_addr, rd_addr, wr_gray, rd_gray,
           full, empty, level, err
  );
endinterface

// File: rtl/gray_fifo_ptr_ctrl_gray_ptr.sv
// AW+1-bit binary pointer with a Gray copy registered alongside it.
// rst and clr both zero the pointer; rst wins, clr wins over inc.
module gray_ptr
  import memctrl_gray_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [AW:0] bin,
  output logic [AW:0] gray
);

  logic [AW:0]           bin_q, bin_d;
  logic [AW:0]           gray_q, gray_d;
  logic [GRAY_MAX_W-1:0] gray_full;

  // Next pointer; wrap from all-ones to zero falls out of the adder.
  always_comb begin
    bin_d = bin_q;
    if (clr)      bin_d = '0;
    else if (inc) bin_d = bin_q + (AW+1)'(1);
    gray_full = bin2gray(GRAY_MAX_W'(bin_d));
    gray_d    = gray_full[AW:0];
  end

  // Pointer registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;

endmodule

// File: rtl/gray_fifo_ptr_ctrl.sv
// Single-clock FIFO pointer controller with Gray-coded pointers.
// Grants, addresses, full/empty and level for a 2**AW-entry buffer.
// Define GRAY_FIFO_PTR_ERR_EN to build the sticky overflow/underflow flag;
// otherwise err is tied low.
module gray_fifo_ptr_ctrl
  import memctrl_gray_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  gray_fifo_ptr_ctrl_if.slave      bus
);

  logic [AW:0] wr_bin, rd_bin;
  logic [AW:0] wr_gray, rd_gray;
  logic        full, empty;
  logic        wr_grant, rd_grant;
  logic [AW:0] level_q, level_d;

  // Flags decode straight from the registered Gray pointers.
  assign empty = (wr_gray == rd_gray);
  assign full  = (wr_gray == {~rd_gray[AW:AW-1], rd_gray[AW-2:0]});

  // Full blocks writes, empty blocks reads, so a simultaneous pair at a
  // boundary only grants the side that can make progress.
  assign wr_grant = bus.wr_req & ~full  & ~bus.flush & ~rst;
  assign rd_grant = bus.rd_req & ~empty & ~bus.flush & ~rst;

  gray_ptr #(.AW(AW)) u_wr_ptr (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.flush),
    .inc  (wr_grant),
    .bin  (wr_bin),
    .gray (wr_gray)
  );

  gray_ptr #(.AW(AW)) u_rd_ptr (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.flush),
    .inc  (rd_grant),
    .bin  (rd_bin),
    .gray (rd_gray)
  );

  // Occupancy tracks wr_bin - rd_bin incrementally, in step with the pointers.
  always_comb begin
    level_d = level_q;
    if (bus.flush)                 level_d = '0;
    else if (wr_grant & ~rd_grant) level_d = level_q + (AW+1)'(1);
    else if (rd_grant & ~wr_grant) level_d = level_q - (AW+1)'(1);
  end

  // Level register.
  always_ff @(posedge clk) begin
    if (rst) level_q <= '0;
    else     level_q <= level_d;
  end

`ifdef GRAY_FIFO_PTR_ERR_EN
  logic err_q, err_d;

  // Sticky: a refused request at a boundary sets it; only flush/rst clear it.
  always_comb begin
    err_d = err_q;
    if (bus.flush)
      err_d = 1'b0;
    else if ((bus.wr_req & full) | (bus.rd_req & empty))
      err_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.wr_grant = wr_grant;
  assign bus.rd_grant = rd_grant;
  assign bus.wr_addr  = wr_bin[AW-1:0];
  assign bus.rd_addr  = rd_bin[AW-1:0];
  assign bus.wr_gray  = wr_gray;
  assign bus.rd_gray  = rd_gray;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level_q;

endmodule

// File: doc/gray_fifo_ptr_ctrl.md
GRAY_FIFO_PTR_CTRL -- requirements
Module: gray_fifo_ptr_ctrl

Interface
REQ-001 SHALL have parameter: AW, 4, address width; buffer depth = 2**AW; legal range 2..15.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: flush  input  1  synchronous pointer clear.
REQ-005 SHALL have port: wr_req  input  1  write request.
REQ-006 SHALL have port: rd_req  input  1  read request.
REQ-007 SHALL have port: wr_grant  output  1  write accepted this cycle.
REQ-008 SHALL have port: rd_grant  output  1  read accepted this cycle.
REQ-009 SHALL have port: wr_addr  output  AW  memory write address, binary.
REQ-010 SHALL have port: rd_addr  output  AW  memory read address, binary.
REQ-011 SHALL have port: wr_gray  output  AW+1  Gray-coded write pointer, including wrap bit.
REQ-012 SHALL have port: rd_gray  output  AW+1  Gray-coded read pointer, including wrap bit.
REQ-013 SHALL have port: full  output  1  no free entry.
REQ-014 SHALL have port: empty  output  1  no valid entry.
REQ-015 SHALL have port: level  output  AW+1  occupied entries, 0..2**AW.
REQ-016 SHALL have port: err  output  1  sticky overflow/underflow flag (macro-dependent, see Configuration).

Function
REQ-017 SHALL hold each pointer as an AW+1-bit binary register; the Gray pointer is registered alongside it and SHALL equal bin ^ (bin >> 1) every cycle.
REQ-018 wr_addr/rd_addr SHALL be the low AW bits of the binary pointers; they are valid in the same cycle as the grant.
REQ-019 empty SHALL be wr_gray == rd_gray, decoded combinationally from registered pointers.
REQ-020 full SHALL be wr_gray == {~rd_gray[AW:AW-1], rd_gray[AW-2:0]}, decoded combinationally from registered pointers.
REQ-021 Grants:
- wr_grant = wr_req & ~full & ~flush.
- rd_grant = rd_req & ~empty & ~flush.
REQ-022 A granted pointer SHALL increment by one at the next edge; AW+1-bit wrap from all-ones to zero SHALL be seamless.
REQ-023 Write and read granted in the same cycle SHALL advance both pointers; level stays unchanged.
REQ-024 When full, a simultaneous rd_req and wr_req SHALL grant only the read; the write is refused that cycle.
REQ-025 When empty, a simultaneous rd_req and wr_req SHALL grant only the write; the read is refused that cycle.
REQ-026 level SHALL be wr_bin - rd_bin modulo 2**(AW+1), registered with the pointers.
REQ-027 flush SHALL override all requests: both pointers and level go to 0 at the next edge; grants are 0 during the flush cycle.
REQ-028 Latency: a grant in cycle N SHALL be reflected in pointers, flags and level in cycle N+1.

Reset
REQ-029 rst SHALL take priority over flush and requests.
REQ-030 On reset: all pointers 0, level 0, empty 1, full 0, grants 0, err 0.
REQ-031 Reset asserted mid-operation SHALL discard the occupancy within one cycle; no grant is issued while rst = 1.

Configuration
REQ-032 Macro GRAY_FIFO_PTR_ERR_EN SHALL control error flagging.
- Defined: err sets on (wr_req & full) or (rd_req & empty) when flush = 0; it clears only on rst or flush.
- Undefined: err is tied to 0 and no error logic is built.

Structure
REQ-033 Package memctrl_gray_pkg SHALL hold the bin-to-Gray function and the default AW constant.
REQ-034 Sub-module gray_ptr SHALL be instantiated twice (write and read). Its function: AW+1-bit binary+Gray register with inc, clr and rst inputs.

Verification
REQ-035 Reset, then 16 writes with no reads (AW=4) -> wr_grant high for all 16; full=1 and level=16 after the 16th; 17th write refused.
REQ-036 From full, 16 reads -> rd_addr runs 0..15; empty=1 and level=0 after the last; a further read is refused and sets err when the macro is defined.
REQ-037 Continuous simultaneous writes and reads for 40 cycles starting at level 3 -> level stays 3; pointers wrap past 31 to 0; every Gray step changes exactly one bit.
REQ-038 Full with wr_req=rd_req=1 -> only rd_grant=1, level goes 16 to 15. Empty with both requests -> only wr_grant=1, level goes 0 to 1.
REQ-039 At level 7, flush=1 with both requests -> grants 0; next cycle pointers=0, level=0, empty=1, err=0.
REQ-040 At level 9, rst asserted for 1 cycle -> next cycle matches the reset state in REQ-030; the stream resumes at address 0.
